input_conditioner: RTL and testbench

//  Front-end stage that directly feeds the coffee-machine FSM and display decoders.

---
 rtl/input_conditioner.sv | 116 +++++++++++
 tb/tb_input_conditioner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Per-bit pin conditioner: 2-flop synchroniser, debounce counter, registered RISE/FALL/CHANGE.
// Build option: define AUTOREPEAT_EN to add auto-repeat RISE pulses on bits selected by REPEAT_MASK.
module input_conditioner #(
  parameter int              N_IN          = 8,
  parameter int              DEB_CYCLES    = 50000,
  parameter logic [N_IN-1:0] INV_MASK      = '0,
  parameter int              REPEAT_CYCLES = 500000,
  parameter logic [N_IN-1:0] REPEAT_MASK   = N_IN'(8'h60)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] clean,
  output logic [N_IN-1:0] rise,
  output logic [N_IN-1:0] fall,
  output logic            change
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic [N_IN-1:0] sync1;
  logic [N_IN-1:0] sync2;
  logic [CW-1:0]   cnt     [N_IN];
  logic [CW-1:0]   cnt_nxt [N_IN];
  logic [N_IN-1:0] differ;
  logic [N_IN-1:0] accept;
  logic [N_IN-1:0] clean_nxt;
  logic [N_IN-1:0] edge_rise;
  logic [N_IN-1:0] edge_fall;
  logic [N_IN-1:0] rep_fire;
  logic [N_IN-1:0] rise_nxt;

  // Inversion sits ahead of sync1 so the two synchroniser flops stay back to back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in ^ INV_MASK;
      sync2 <= sync1;
    end
  end

  always_comb begin
    differ  = '0;
    accept  = '0;
    cnt_nxt = '{default: '0};
    for (int i = 0; i < N_IN; i++) begin
      differ[i] = sync2[i] ^ clean[i];
      accept[i] = differ[i] && (cnt[i] == DEB_LAST);
      if (!differ[i] || accept[i]) begin
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  assign clean_nxt = (clean & ~accept) | (sync2 & accept);
  assign edge_rise = accept & sync2;
  assign edge_fall = accept & ~sync2;

`ifdef AUTOREPEAT_EN
  localparam int            RW      = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RC_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rc     [N_IN];
  logic [RW-1:0] rc_nxt [N_IN];

  // Repeat timer only runs while the debounced level sits high with no edge this cycle.
  always_comb begin
    rep_fire = '0;
    rc_nxt   = '{default: '0};
    for (int i = 0; i < N_IN; i++) begin
      if (REPEAT_MASK[i] && clean[i] && !accept[i]) begin
        if (rc[i] == RC_LAST) begin
          rep_fire[i] = 1'b1;
          rc_nxt[i]   = '0;
        end else begin
          rc_nxt[i]   = rc[i] + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc <= '{default: '0};
    end else begin
      rc <= rc_nxt;
    end
  end
`else
  assign rep_fire = '0;
`endif

  assign rise_nxt = edge_rise | rep_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '{default: '0};
      clean  <= '0;
      rise   <= '0;
      fall   <= '0;
      change <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      clean  <= clean_nxt;
      rise   <= rise_nxt;
      fall   <= edge_fall;
      change <= |(rise_nxt | edge_fall);
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: reference model pushes expected outputs each edge,
// a negedge monitor pops and compares; directed counts cover glitch, bounce, reset and repeat cases.
module tb_input_conditioner;

  localparam int         N     = 8;
  localparam int         DEB   = 4;
  localparam int         REP   = 8;
  localparam logic [7:0] INV   = 8'h01;
  localparam logic [7:0] RMASK = 8'h60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] raw_in = 8'h00;
  logic [7:0] clean, rise, fall;
  logic       change;

  input_conditioner #(
    .N_IN(N), .DEB_CYCLES(DEB), .INV_MASK(INV),
    .REPEAT_CYCLES(REP), .REPEAT_MASK(RMASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .clean(clean), .rise(rise), .fall(fall), .change(change)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] r;
    logic [7:0] f;
    logic       ch;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] sq[$];
  int         run[8];
  int         age[8];
  logic [7:0] mclean = 8'h00;

  // Reference: a level is accepted once it has been seen (two edges late) for DEB consecutive edges.
  always @(posedge clk) begin : model
    exp_t       e;
    logic [7:0] v;
    logic [7:0] r;
    logic [7:0] f;
    if (!rst_n) begin
      sq.delete();
      mclean = 8'h00;
      for (int i = 0; i < 8; i++) begin
        run[i] = 0;
        age[i] = 0;
      end
      e = '0;
    end else begin
      sq.push_back(raw_in ^ INV);
      v = (sq.size() >= 3) ? sq[sq.size()-3] : 8'h00;
      if (sq.size() > 3) void'(sq.pop_front());
      r = 8'h00;
      f = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (v[i] != mclean[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            mclean[i] = v[i];
            run[i] = 0;
            age[i] = 0;
            if (v[i]) r[i] = 1'b1;
            else      f[i] = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
`ifdef AUTOREPEAT_EN
        if (RMASK[i] && mclean[i] && !r[i] && !f[i]) begin
          age[i]++;
          if (age[i] % REP == 0) r[i] = 1'b1;
        end
`endif
      end
      e = '{c: mclean, r: r, f: f, ch: |(r | f)};
    end
    sbq.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t a;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (!rst_n) e = '0;
      a = '{c: clean, r: rise, f: fall, ch: change};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs t=%0t got clean=%h rise=%h fall=%h change=%b want clean=%h rise=%h fall=%h change=%b",
                 $time, a.c, a.r, a.f, a.ch, e.c, e.r, e.f, e.ch);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  int rc5, rc4, rc6, fc6, pulses5;

  initial begin
    // reset with all (inverted-adjusted) pins active
    rst_n  = 1'b0;
    raw_in = 8'hFE;
    repeat (3) @(negedge clk);
    check("reset_clean", int'(clean), 0);
    check("reset_pulses", int'({rise, fall, change}), 0);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("release_clean_ff", int'(clean), 8'hFF);

    // all inactive
    raw_in = 8'h01;
    repeat (12) @(negedge clk);
    check("idle_clean", int'(clean), 0);

    // short glitch on bit 5
    pulses5 = 0;
    raw_in[5] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      pulses5 += int'(rise[5]) + int'(fall[5]) + int'(clean[5]);
    end
    raw_in[5] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      pulses5 += int'(rise[5]) + int'(fall[5]) + int'(clean[5]);
    end
    check("glitch_bit5", pulses5, 0);

    // bouncing press and release on bit 6
    rc6 = 0;
    fc6 = 0;
    for (int j = 0; j < 26; j++) begin
      raw_in[6] = (j < 10) ? ((j < 4) ? ~j[0] : 1'b1) : 1'b0;
      @(negedge clk);
      rc6 += int'(rise[6]);
      fc6 += int'(fall[6]);
    end
    check("bounce_rise6", rc6, 1);
    check("bounce_fall6", fc6, 1);

    // async reset mid-count on bit 1
    raw_in = 8'h03;
    repeat (10) @(negedge clk);
    check("pre_reset_clean1", int'(clean[1]), 1);
    raw_in[1] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_clean", int'(clean), 0);
    check("async_pulses", int'({rise, fall, change}), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_reset_clean1", int'(clean[1]), 0);

    // long hold on bits 4 and 5
    raw_in = 8'h01;
    repeat (10) @(negedge clk);
    raw_in = 8'h31;
    rc4 = 0;
    rc5 = 0;
    for (int j = 0; j < 35; j++) begin
      @(negedge clk);
      rc4 += int'(rise[4]);
      rc5 += int'(rise[5]);
    end
`ifdef AUTOREPEAT_EN
    check("hold_rise5", rc5, 4);
`else
    check("hold_rise5", rc5, 1);
`endif
    check("hold_rise4", rc4, 1);
    raw_in = 8'h01;
    repeat (10) @(negedge clk);

    // randomised activity: alternating flip-heavy and hold windows, occasional async reset
    for (int c = 0; c < 1500; c++) begin
      if (((c / 60) % 2) == 0) begin
        for (int b = 0; b < 8; b++)
          if ($urandom_range(0, 7) == 0) raw_in[b] = ~raw_in[b];
      end
      if ($urandom_range(0, 299) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sbq.size() <= 1 ? 1 : 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
